// File: rtl/keypad_pkg.sv
// Shared types and constants for the 3x4 keypad responder.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_BOUNCE_IN  = 2'd1,
    ST_HOLD       = 2'd2,
    ST_BOUNCE_OUT = 2'd3
  } kp_state_e;

  typedef logic [3:0] key_code_t;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } key_pos_t;

  localparam key_code_t   NUM_KEYS  = 4'd12;
  localparam logic [3:0]  ROW_IDLE  = 4'b1111;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Key code to matrix position: row = code/3, column = code%3.
  function automatic key_pos_t key_to_pos(input key_code_t code);
    key_pos_t p;
    p.row = 2'(code / 4'd3);
    p.col = 2'(code % 4'd3);
    return p;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used as the contact-bounce source.
// next_lsb_o is bit 0 of the value the register takes at the next edge, so a
// registered consumer sampling it stays aligned with the LFSR register.
module lfsr16 (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic [15:0] seed_i,
  output logic        next_lsb_o
);

  logic [15:0] lfsr_q, lfsr_d;

  // Shift right, feedback from taps 16,14,13,11 into the MSB.
  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
  end

  // LFSR state register, reloaded with the seed on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= seed_i;
    else         lfsr_q <= lfsr_d;
  end

  assign next_lsb_o = lfsr_d[0];

endmodule

// File: rtl/keypad_responder.sv
// Matrix-keypad responder: emulates a pressed key on the row lines in answer
// to the scanner's column strobes. Build option KEYPAD_BOUNCE_EN adds
// pseudo-random contact bounce phases around the stable hold phase.
module keypad_responder
  import keypad_pkg::*;
#(
  parameter int unsigned NUM_COLS      = 3,
  parameter int unsigned NUM_ROWS      = 4,
  parameter int unsigned HOLD_CYCLES   = 5000000,
  parameter int unsigned BOUNCE_CYCLES = 200000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_COLS-1:0] col,
  input  key_code_t           press_key,
  input  logic                press_valid,
  output logic                press_ready,
  output logic [NUM_ROWS-1:0] row,
  output logic                busy,
  output logic                key_down,
  output logic                bad_key
);

  localparam int unsigned MAX_CYC = (HOLD_CYCLES > BOUNCE_CYCLES) ? HOLD_CYCLES : BOUNCE_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC == 0) ? 1 : $clog2(MAX_CYC + 1);
  // A phase of N cycles loads N-1 and leaves when the counter reads zero.
  localparam logic [CNT_W-1:0] HOLD_LOAD =
    (HOLD_CYCLES == 0) ? '0 : CNT_W'(HOLD_CYCLES - 1);
`ifdef KEYPAD_BOUNCE_EN
  localparam logic [CNT_W-1:0] BOUNCE_LOAD =
    (BOUNCE_CYCLES == 0) ? '0 : CNT_W'(BOUNCE_CYCLES - 1);
`endif

  kp_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  key_pos_t         tgt_q, tgt_d;
  logic             key_down_q, key_down_d;
  logic             bad_key_q, bad_key_d;
  logic             bounce_bit;

`ifdef KEYPAD_BOUNCE_EN
  lfsr16 u_lfsr (
    .clk_i      (clk),
    .rst_ni     (rst),
    .en_i       (1'b1),
    .seed_i     (LFSR_SEED),
    .next_lsb_o (bounce_bit)
  );
`else
  assign bounce_bit = 1'b0;
`endif

  // Next-state, phase counter, key latch and registered contact value.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tgt_d     = tgt_q;
    bad_key_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (press_valid) begin
          if (press_key < NUM_KEYS) begin
            tgt_d = key_to_pos(press_key);
`ifdef KEYPAD_BOUNCE_EN
            state_d = ST_BOUNCE_IN;
            cnt_d   = BOUNCE_LOAD;
`else
            state_d = ST_HOLD;
            cnt_d   = HOLD_LOAD;
`endif
          end else begin
            bad_key_d = 1'b1;
          end
        end
      end
`ifdef KEYPAD_BOUNCE_EN
      ST_BOUNCE_IN: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_BOUNCE_OUT: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
`endif
      ST_HOLD: begin
        if (cnt_q == '0) begin
`ifdef KEYPAD_BOUNCE_EN
          state_d = ST_BOUNCE_OUT;
          cnt_d   = BOUNCE_LOAD;
`else
          state_d = ST_IDLE;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Contact follows the state being entered so key_down lines up with it.
    unique case (state_d)
      ST_HOLD:                    key_down_d = 1'b1;
      ST_BOUNCE_IN, ST_BOUNCE_OUT: key_down_d = bounce_bit;
      default:                    key_down_d = 1'b0;
    endcase
  end

  // State registers; reset discards any latched key.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      tgt_q      <= '0;
      key_down_q <= 1'b0;
      bad_key_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tgt_q      <= tgt_d;
      key_down_q <= key_down_d;
      bad_key_q  <= bad_key_d;
    end
  end

  // Switch-matrix behaviour: the closed contact pulls its row low only while
  // its column strobe is low; no latency from col to row.
  always_comb begin
    row = NUM_ROWS'(ROW_IDLE);
    if (key_down_q && !col[tgt_q.col]) row[tgt_q.row] = 1'b0;
  end

  assign press_ready = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign key_down    = key_down_q;
  assign bad_key     = bad_key_q;

endmodule

// File: tb/tb_keypad_responder.sv
module tb_keypad_responder;

  localparam int unsigned HOLD   = 100;
  localparam int unsigned BOUNCE = 20;
`ifdef KEYPAD_BOUNCE_EN
  localparam int unsigned BW = BOUNCE;
`else
  localparam int unsigned BW = 0;
`endif
  localparam int unsigned TOTAL = HOLD + 2 * BW;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] col = 3'b111;
  logic [3:0] press_key = 4'd0;
  logic       press_valid = 1'b0;
  logic       press_ready;
  logic [3:0] row;
  logic       busy, key_down, bad_key;

  int checks = 0;
  int errors = 0;

  keypad_responder #(
    .HOLD_CYCLES   (HOLD),
    .BOUNCE_CYCLES (BOUNCE)
  ) dut (
    .clk         (clk),
    .rst         (rst_n),
    .col         (col),
    .press_key   (press_key),
    .press_valid (press_valid),
    .press_ready (press_ready),
    .row         (row),
    .busy        (busy),
    .key_down    (key_down),
    .bad_key     (bad_key)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_left = busy cycles still to come; position in the press sequence is
  // TOTAL - m_left, which selects bounce-in / hold / bounce-out.
  int          m_left = 0;
  logic [15:0] m_lfsr = 16'hACE1;
  int          m_r = 0;
  int          m_c = 0;
  logic        m_bad = 1'b0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic fb;
    fb = v[0] ^ v[2] ^ v[3] ^ v[5];
    return {fb, v[15:1]};
  endfunction

  function automatic logic exp_contact();
    int pos;
    if (m_left == 0) return 1'b0;
    pos = int'(TOTAL) - m_left;
`ifdef KEYPAD_BOUNCE_EN
    if (pos < int'(BW) || pos >= int'(BW + HOLD)) return m_lfsr[0];
`endif
    return 1'b1;
  endfunction

  function automatic logic [3:0] exp_row();
    logic [3:0] r;
    r = 4'hF;
    if (exp_contact() && col[m_c] == 1'b0) r[m_r] = 1'b0;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_lfsr <= 16'hACE1;
      m_r    <= 0;
      m_c    <= 0;
      m_bad  <= 1'b0;
    end else begin
      m_lfsr <= lfsr_step(m_lfsr);
      m_bad  <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
      end else if (press_valid) begin
        if (press_key < 4'd12) begin
          m_left <= int'(TOTAL);
          m_r    <= int'(press_key) / 3;
          m_c    <= int'(press_key) % 3;
        end else begin
          m_bad <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("row", row, exp_row());
    chk("press_ready", press_ready, m_left == 0);
    chk("busy", busy, m_left != 0);
    chk("key_down", key_down, exp_contact());
    chk("bad_key", bad_key, m_bad);
  end

  // ---------------- stimulus helpers ----------------
  task automatic press(input logic [3:0] k);
    logic ok;
    ok = 1'b0;
    press_valid = 1'b1;
    press_key   = k;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (press_ready) begin
        @(posedge clk);
        #2;
        press_valid = 1'b0;
        ok = 1'b1;
        break;
      end
    end
    press_valid = 1'b0;
    chk("press_accept", ok, 1'b1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("wait_idle", busy, 1'b0);
  endtask

  initial begin
    logic saw_lo_in, saw_hi_in, saw_lo_out, saw_hi_out, got, r;
    int   blen, hold_ok, n, gap;

    // 1: reset
    #2 rst_n = 1'b0;
    #5;
    chk("rst_row", row, 4'b1111);
    chk("rst_ready", press_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    #5 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_row", row, 4'b1111);
    chk("post_rst_ready", press_ready, 1'b1);
    chk("post_rst_busy", busy, 1'b0);

    // 2: key 5 (row 1, col 2)
    col = 3'b110;
    press(4'd5);
    for (int i = 0; i < int'(BW); i++) begin
      @(negedge clk);
      chk("k5_other_col_row", row, 4'b1111);
    end
    col = 3'b011;
    for (int i = 0; i < int'(HOLD); i++) begin
      @(negedge clk);
      chk("k5_hold_row", row, 4'b1101);
    end
    col = 3'b110;
    @(negedge clk);
    chk("k5_wrong_col_row", row, 4'b1111);
    wait_idle();

    // 3: key 0 with col fixed
    col = 3'b110;
    press(4'd0);
    saw_lo_in = 0; saw_hi_in = 0; saw_lo_out = 0; saw_hi_out = 0;
    blen = 0; hold_ok = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (!busy) break;
      if (blen < int'(BW)) begin
        if (row == 4'b1110) saw_lo_in = 1'b1;
        if (row == 4'b1111) saw_hi_in = 1'b1;
      end else if (blen < int'(BW + HOLD)) begin
        if (row == 4'b1110) hold_ok++;
      end else begin
        if (row == 4'b1110) saw_lo_out = 1'b1;
        if (row == 4'b1111) saw_hi_out = 1'b1;
      end
      blen++;
    end
    chk("k0_busy_len", blen, TOTAL);
    chk("k0_hold_rows", hold_ok, HOLD);
`ifdef KEYPAD_BOUNCE_EN
    chk("k0_bin_low", saw_lo_in, 1'b1);
    chk("k0_bin_high", saw_hi_in, 1'b1);
    chk("k0_bout_low", saw_lo_out, 1'b1);
    chk("k0_bout_high", saw_hi_out, 1'b1);
`endif

    // 4: bad key
    press(4'd13);
    @(negedge clk);
    chk("bad_pulse", bad_key, 1'b1);
    chk("bad_busy", busy, 1'b0);
    chk("bad_row", row, 4'b1111);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bad_single", bad_key, 1'b0);
      chk("bad_busy_after", busy, 1'b0);
    end

    // 5: request held during HOLD of key 3
    col = 3'b110;
    press(4'd3);
    repeat (BW + 10) @(posedge clk);
    #2;
    press_valid = 1'b1;
    press_key   = 4'd7;
    n = 0; got = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (press_ready) begin
        got = 1'b1;
        break;
      end
      n++;
    end
    chk("held_seen", got, 1'b1);
    chk("held_wait_cycles", n, TOTAL - BW - 10);
    chk("held_idle_busy", busy, 1'b0);
    @(posedge clk);
    #2 press_valid = 1'b0;
    @(negedge clk);
    chk("restart_busy", busy, 1'b1);
    chk("restart_ready", press_ready, 1'b0);
    wait_idle();

    // 6: reset during HOLD of key 11
    col = 3'b011;
    press(4'd11);
    repeat (BW + 50) @(negedge clk);
    chk("k11_hold_row", row, 4'b0111);
    #2 rst_n = 1'b0;
    #1;
    chk("async_row", row, 4'b1111);
    chk("async_busy", busy, 1'b0);
    chk("async_key_down", key_down, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("after_rst_busy", busy, 1'b0);
    chk("after_rst_ready", press_ready, 1'b1);
    chk("after_rst_row", row, 4'b1111);

    // Random phase: random keys (incl. invalid), gaps and column patterns.
    gap = 0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      r = press_ready;
      @(posedge clk);
      #2;
      if (press_valid && r) begin
        press_valid = 1'b0;
        gap = int'($urandom_range(0, 3));
      end else if (!press_valid) begin
        if (gap == 0) begin
          press_valid = 1'b1;
          press_key   = 4'($urandom_range(0, 15));
        end else begin
          gap--;
        end
      end
      if ($urandom_range(0, 9) < 7) begin
        case ($urandom_range(0, 2))
          0:       col = 3'b110;
          1:       col = 3'b101;
          default: col = 3'b011;
        endcase
      end else begin
        col = 3'($urandom_range(0, 7));
      end
    end
    press_valid = 1'b0;
    col = 3'b111;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
